// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: opcode/status inputs and control outputs of the multicycle controller.
interface multicycle_controller_if #(
    parameter int ALU_OP_W  = 2,
    parameter int IMM_SRC_W = 3
);
    logic [6:0]           op_i;
    logic [2:0]           funct3_i;
    logic                 zero_i;
    logic                 mem_ready_i;
    logic                 pc_write_o;
    logic                 ir_write_o;
    logic                 reg_write_o;
    logic                 mem_write_o;
    logic                 mem_read_o;
    logic                 adr_src_o;
    logic [1:0]           result_src_o;
    logic [1:0]           alu_src_a_o;
    logic [1:0]           alu_src_b_o;
    logic [ALU_OP_W-1:0]  alu_op_o;
    logic [IMM_SRC_W-1:0] imm_src_o;
    logic [3:0]           state_o;
    logic                 illegal_o;

    modport master (
        input  op_i, funct3_i, zero_i, mem_ready_i,
        output pc_write_o, ir_write_o, reg_write_o, mem_write_o, mem_read_o, adr_src_o,
               result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, imm_src_o, state_o, illegal_o
    );
    modport slave (
        output op_i, funct3_i, zero_i, mem_ready_i,
        input  pc_write_o, ir_write_o, reg_write_o, mem_write_o, mem_read_o, adr_src_o,
               result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, imm_src_o, state_o, illegal_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle control FSM with Moore outputs and sticky illegal-opcode trap.
// Define MULTICYCLE_UTYPE_EN to add the UTYPE state for lui/auipc (otherwise they trap).
module multicycle_controller #(
    parameter int ALU_OP_W      = 2,
    parameter int IMM_SRC_W     = 3,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3, S_MEMWB = 4'd4,
        S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_ALUWB = 4'd7, S_EXECI = 4'd8, S_JAL = 4'd9,
        S_BRANCH = 4'd10, S_UTYPE = 4'd11, S_TRAP = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t     r_state, w_next;
    logic       r_illegal;
    logic       w_rdy;
    logic [1:0] w_alu_op;
    logic [2:0] w_imm;
    logic       w_unused;

    assign w_rdy    = (MEM_HANDSHAKE != 0) ? bus.mem_ready_i : 1'b1;
    assign w_unused = ^bus.funct3_i[2:1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_TRAP);
        end
    end

    always_comb begin
        w_next           = r_state;
        w_alu_op         = 2'b00;
        bus.pc_write_o   = 1'b0;
        bus.ir_write_o   = 1'b0;
        bus.reg_write_o  = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_read_o   = 1'b0;
        bus.adr_src_o    = 1'b0;
        bus.result_src_o = 2'b00;
        bus.alu_src_a_o  = 2'b00;
        bus.alu_src_b_o  = 2'b00;
        case (r_state)
            S_FETCH: begin
                // rst_ni gating keeps the PC/IR writes off while reset holds the FSM here
                bus.mem_read_o   = 1'b1;
                bus.alu_src_b_o  = 2'b10;
                bus.result_src_o = 2'b10;
                bus.ir_write_o   = w_rdy & rst_ni;
                bus.pc_write_o   = w_rdy & rst_ni;
                w_next           = w_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.alu_src_a_o = 2'b01;
                bus.alu_src_b_o = 2'b01;
                case (bus.op_i)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BRANCH:         w_next = S_BRANCH;
`ifdef MULTICYCLE_UTYPE_EN
                    OP_LUI, OP_AUIPC:  w_next = S_UTYPE;
`endif
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a_o = 2'b10;
                bus.alu_src_b_o = 2'b01;
                w_next          = (bus.op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.mem_read_o = 1'b1;
                bus.adr_src_o  = 1'b1;
                w_next         = w_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                bus.result_src_o = 2'b01;
                bus.reg_write_o  = 1'b1;
                w_next           = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.mem_write_o = 1'b1;
                bus.adr_src_o   = 1'b1;
                w_next          = w_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                bus.alu_src_a_o = 2'b10;
                w_alu_op        = 2'b10;
                w_next          = S_ALUWB;
            end
            S_EXECI: begin
                bus.alu_src_a_o = 2'b10;
                bus.alu_src_b_o = 2'b01;
                w_alu_op        = 2'b10;
                w_next          = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_write_o = 1'b1;
                w_next          = S_FETCH;
            end
            S_JAL: begin
                bus.alu_src_a_o = 2'b01;
                bus.alu_src_b_o = 2'b10;
                bus.pc_write_o  = 1'b1;
                w_next          = S_ALUWB;
            end
            S_BRANCH: begin
                // funct3[0] selects bne, which inverts the taken sense of the zero flag
                bus.alu_src_a_o = 2'b10;
                w_alu_op        = 2'b01;
                bus.pc_write_o  = bus.zero_i ^ bus.funct3_i[0];
                w_next          = S_FETCH;
            end
`ifdef MULTICYCLE_UTYPE_EN
            S_UTYPE: begin
                bus.alu_src_a_o = (bus.op_i == OP_LUI) ? 2'b11 : 2'b01;
                bus.alu_src_b_o = 2'b01;
                w_next          = S_ALUWB;
            end
`endif
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    assign w_imm = (bus.op_i == OP_STORE)                       ? 3'b001 :
                   (bus.op_i == OP_BRANCH)                      ? 3'b010 :
                   (bus.op_i == OP_JAL)                         ? 3'b011 :
                   (bus.op_i == OP_LUI || bus.op_i == OP_AUIPC) ? 3'b100 : 3'b000;

    assign bus.imm_src_o = IMM_SRC_W'(w_imm);
    assign bus.alu_op_o  = ALU_OP_W'(w_alu_op);
    assign bus.state_o   = r_state;
    assign bus.illegal_o = r_illegal;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard-driven bench for the multicycle controller FSM.
module tb_multicycle_controller;
    typedef struct packed {
        logic [6:0] op;
        logic       rdy;
        logic [3:0] st;
        logic       pcw;
        logic       rw;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    step_t q[$];

    multicycle_controller_if bus ();

    multicycle_controller #(.ALU_OP_W(2), .IMM_SRC_W(3), .MEM_HANDSHAKE(1)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [6:0] op, input logic rdy, input logic [3:0] st, input logic pcw, input logic rw);
        q.push_back('{op, rdy, st, pcw, rw});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.op_i = 7'b0110011; bus.funct3_i = 3'b000; bus.zero_i = 1'b0; bus.mem_ready_i = 1'b1;
        #3;
        n_cmp++; if (bus.state_o !== 4'd0) begin n_err++; $display("FAIL reset state: got %0d expected 0", bus.state_o); end
        n_cmp++; if (bus.illegal_o !== 1'b0) begin n_err++; $display("FAIL reset illegal: got %b expected 0", bus.illegal_o); end
        n_cmp++; if (bus.ir_write_o !== 1'b0 || bus.pc_write_o !== 1'b0) begin n_err++; $display("FAIL reset ir/pc write: got %b%b expected 00", bus.ir_write_o, bus.pc_write_o); end
        n_cmp++; if ({bus.mem_read_o, bus.adr_src_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.result_src_o} !== 8'b1_0_00_10_10) begin n_err++; $display("FAIL reset fetch outputs: got %b expected 10001010", {bus.mem_read_o, bus.adr_src_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.result_src_o}); end
        @(posedge clk); #1;
        n_cmp++; if (bus.state_o !== 4'd0) begin n_err++; $display("FAIL reset hold state: got %0d expected 0", bus.state_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.pc_write_o !== 1'b1 || bus.ir_write_o !== 1'b1) begin n_err++; $display("FAIL released fetch pc/ir: got %b%b expected 11", bus.pc_write_o, bus.ir_write_o); end
        @(negedge clk); #1;
        n_cmp++; if (bus.state_o !== 4'd1) begin n_err++; $display("FAIL first edge decode: got %0d expected 1", bus.state_o); end
    endtask

    task automatic test_rtype();
        step_t s;
        do_reset();
        push(7'b0110011, 1, 0, 1, 0); push(7'b0110011, 1, 1, 0, 0); push(7'b0110011, 1, 6, 0, 0);
        push(7'b0110011, 1, 7, 0, 1); push(7'b0110011, 1, 0, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            bus.op_i = s.op; bus.mem_ready_i = s.rdy;
            #1;
            n_cmp++; if (bus.state_o !== s.st) begin n_err++; $display("FAIL rtype state: got %0d expected %0d", bus.state_o, s.st); end
            n_cmp++; if (bus.reg_write_o !== s.rw) begin n_err++; $display("FAIL rtype reg_write st%0d: got %b expected %b", s.st, bus.reg_write_o, s.rw); end
            if (s.st == 4'd6) begin
                n_cmp++; if (bus.alu_op_o !== 2'b10 || bus.alu_src_a_o !== 2'b10) begin n_err++; $display("FAIL rtype execr alu: got %b/%b expected 10/10", bus.alu_op_o, bus.alu_src_a_o); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_wait();
        step_t s;
        logic       rdy_t [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        logic [3:0] st_t  [9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        do_reset();
        for (int i = 0; i < 9; i++) push(7'b0000011, rdy_t[i], st_t[i], st_t[i] == 0, st_t[i] == 4);
        while (q.size() > 0) begin
            s = q.pop_front();
            bus.op_i = s.op; bus.mem_ready_i = s.rdy;
            #1;
            n_cmp++; if (bus.state_o !== s.st) begin n_err++; $display("FAIL load state: got %0d expected %0d", bus.state_o, s.st); end
            n_cmp++; if (bus.reg_write_o !== s.rw) begin n_err++; $display("FAIL load reg_write st%0d: got %b expected %b", s.st, bus.reg_write_o, s.rw); end
            if (s.st == 4'd3) begin
                n_cmp++; if (bus.mem_read_o !== 1'b1 || bus.adr_src_o !== 1'b1) begin n_err++; $display("FAIL load memread rd/adr: got %b%b expected 11", bus.mem_read_o, bus.adr_src_o); end
            end
            if (s.st == 4'd4) begin
                n_cmp++; if (bus.result_src_o !== 2'b01) begin n_err++; $display("FAIL load memwb result_src: got %b expected 01", bus.result_src_o); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        step_t s;
        logic [2:0] f3_t [3] = '{3'b001, 3'b001, 3'b000};
        logic       z_t  [3] = '{1'b0, 1'b1, 1'b1};
        logic       pc_t [3] = '{1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 3; c++) begin
            do_reset();
            bus.funct3_i = f3_t[c]; bus.zero_i = z_t[c];
            push(7'b1100011, 1, 0, 1, 0); push(7'b1100011, 1, 1, 0, 0);
            push(7'b1100011, 1, 10, pc_t[c], 0); push(7'b1100011, 1, 0, 1, 0);
            while (q.size() > 0) begin
                s = q.pop_front();
                bus.op_i = s.op; bus.mem_ready_i = s.rdy;
                #1;
                n_cmp++; if (bus.state_o !== s.st) begin n_err++; $display("FAIL branch%0d state: got %0d expected %0d", c, bus.state_o, s.st); end
                n_cmp++; if (bus.pc_write_o !== s.pcw) begin n_err++; $display("FAIL branch%0d pc_write st%0d: got %b expected %b", c, s.st, bus.pc_write_o, s.pcw); end
                if (s.st == 4'd10) begin
                    n_cmp++; if (bus.alu_op_o !== 2'b01 || bus.imm_src_o !== 3'b010) begin n_err++; $display("FAIL branch%0d alu/imm: got %b/%b expected 01/010", c, bus.alu_op_o, bus.imm_src_o); end
                end
                @(negedge clk);
            end
        end
        bus.zero_i = 1'b0; bus.funct3_i = 3'b000;
    endtask

    task automatic test_trap();
        step_t s;
        do_reset();
        push(7'b1111111, 1, 0, 1, 0); push(7'b1111111, 1, 1, 0, 0);
        push(7'b1111111, 1, 12, 0, 0); push(7'b1111111, 1, 12, 0, 0); push(7'b0110011, 1, 12, 0, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            bus.op_i = s.op; bus.mem_ready_i = s.rdy;
            #1;
            n_cmp++; if (bus.state_o !== s.st) begin n_err++; $display("FAIL trap state: got %0d expected %0d", bus.state_o, s.st); end
            n_cmp++; if (bus.illegal_o !== (s.st == 4'd12)) begin n_err++; $display("FAIL trap illegal st%0d: got %b expected %b", s.st, bus.illegal_o, s.st == 4'd12); end
            if (s.st == 4'd12) begin
                n_cmp++; if ({bus.mem_read_o, bus.mem_write_o, bus.reg_write_o, bus.pc_write_o, bus.ir_write_o} !== 5'b0) begin n_err++; $display("FAIL trap enables: got %b expected 00000", {bus.mem_read_o, bus.mem_write_o, bus.reg_write_o, bus.pc_write_o, bus.ir_write_o}); end
            end
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.state_o !== 4'd0 || bus.illegal_o !== 1'b0) begin n_err++; $display("FAIL trap async reset: got st%0d ill%b expected st0 ill0", bus.state_o, bus.illegal_o); end
    endtask

    task automatic test_utype();
        step_t s;
        do_reset();
`ifdef MULTICYCLE_UTYPE_EN
        push(7'b0110111, 1, 0, 1, 0); push(7'b0110111, 1, 1, 0, 0); push(7'b0110111, 1, 11, 0, 0);
        push(7'b0110111, 1, 7, 0, 1); push(7'b0110111, 1, 0, 1, 0);
`else
        push(7'b0110111, 1, 0, 1, 0); push(7'b0110111, 1, 1, 0, 0); push(7'b0110111, 1, 12, 0, 0);
`endif
        while (q.size() > 0) begin
            s = q.pop_front();
            bus.op_i = s.op; bus.mem_ready_i = s.rdy;
            #1;
            n_cmp++; if (bus.state_o !== s.st) begin n_err++; $display("FAIL utype state: got %0d expected %0d", bus.state_o, s.st); end
            n_cmp++; if (bus.imm_src_o !== 3'b100) begin n_err++; $display("FAIL utype imm_src: got %b expected 100", bus.imm_src_o); end
            if (s.st == 4'd11) begin
                n_cmp++; if (bus.alu_src_a_o !== 2'b11 || bus.alu_src_b_o !== 2'b01) begin n_err++; $display("FAIL utype srcA/B: got %b/%b expected 11/01", bus.alu_src_a_o, bus.alu_src_b_o); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store_reset();
        do_reset();
        bus.op_i = 7'b0100011; bus.mem_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (bus.state_o !== 4'd5 || bus.mem_write_o !== 1'b1) begin n_err++; $display("FAIL store memwrite: got st%0d mw%b expected st5 mw1", bus.state_o, bus.mem_write_o); end
        @(negedge clk); #1;
        n_cmp++; if (bus.state_o !== 4'd5 || bus.mem_write_o !== 1'b1) begin n_err++; $display("FAIL store hold: got st%0d mw%b expected st5 mw1", bus.state_o, bus.mem_write_o); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_write_o !== 1'b0 || bus.state_o !== 4'd0) begin n_err++; $display("FAIL store async reset: got st%0d mw%b expected st0 mw0", bus.state_o, bus.mem_write_o); end
        n_cmp++; if ({bus.reg_write_o, bus.pc_write_o, bus.ir_write_o} !== 3'b000) begin n_err++; $display("FAIL store reset enables: got %b expected 000", {bus.reg_write_o, bus.pc_write_o, bus.ir_write_o}); end
        bus.mem_ready_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        step_t s;
        do_reset();
        push(7'b0010011, 0, 0, 0, 0); push(7'b0010011, 1, 0, 1, 0); push(7'b0010011, 1, 1, 0, 0);
        push(7'b0010011, 1, 8, 0, 0); push(7'b0010011, 1, 7, 0, 1);
        push(7'b1101111, 1, 0, 1, 0); push(7'b1101111, 1, 1, 0, 0); push(7'b1101111, 1, 9, 1, 0);
        push(7'b1101111, 1, 7, 0, 1);
        push(7'b0100011, 1, 0, 1, 0); push(7'b0100011, 1, 1, 0, 0); push(7'b0100011, 1, 2, 0, 0);
        push(7'b0100011, 1, 5, 0, 0); push(7'b0100011, 1, 0, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            bus.op_i = s.op; bus.mem_ready_i = s.rdy;
            #1;
            n_cmp++; if (bus.state_o !== s.st) begin n_err++; $display("FAIL b2b state: got %0d expected %0d", bus.state_o, s.st); end
            n_cmp++; if (bus.pc_write_o !== s.pcw) begin n_err++; $display("FAIL b2b pc_write st%0d: got %b expected %b", s.st, bus.pc_write_o, s.pcw); end
            n_cmp++; if (bus.reg_write_o !== s.rw) begin n_err++; $display("FAIL b2b reg_write st%0d: got %b expected %b", s.st, bus.reg_write_o, s.rw); end
            n_cmp++; if (bus.mem_write_o !== (s.st == 4'd5)) begin n_err++; $display("FAIL b2b mem_write st%0d: got %b expected %b", s.st, bus.mem_write_o, s.st == 4'd5); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_trap();
        test_utype();
        test_store_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 2, width of alu_op_o (values above 2 bits zero-extended).
REQ-002 SHALL have parameter IMM_SRC_W, default 3, width of imm_src_o; minimum 3.
REQ-003 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = wait on mem_ready_i, 0 = mem_ready_i treated as constant 1.
REQ-004 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 op_i  in  7  opcode from instruction register; funct3_i  in  3  instruction funct3.
REQ-007 zero_i  in  1  ALU zero flag; mem_ready_i  in  1  memory access complete.
REQ-008 pc_write_o, ir_write_o, reg_write_o, mem_write_o, mem_read_o, adr_src_o  out  1 each.
REQ-009 result_src_o, alu_src_a_o, alu_src_b_o  out  2 each; alu_op_o  out  ALU_OP_W; imm_src_o  out  IMM_SRC_W.
REQ-010 state_o  out  4  current state code; illegal_o  out  1  sticky illegal-opcode flag.

Function
REQ-011 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, UTYPE=11, TRAP=12.
REQ-012 All outputs except imm_src_o and the BRANCH pc_write_o term SHALL be Moore functions of state; unlisted outputs are 0.
REQ-013 FETCH: mem_read=1, adr_src=0, srcA=00, srcB=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready_i; advance to DECODE only when mem_ready_i=1, else hold.
REQ-014 DECODE: srcA=01, srcB=01, alu_op=00; next by op_i: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1101111->JAL, 1100011->BRANCH, 0110111/0010111->UTYPE (macro only), other->TRAP.
REQ-015 MEMADR: srcA=10, srcB=01, alu_op=00; next MEMREAD if op_i=0000011 else MEMWRITE.
REQ-016 MEMREAD: mem_read=1, adr_src=1, result_src=00; to MEMWB when mem_ready_i=1, else hold.
REQ-017 MEMWB: result_src=01, reg_write=1; to FETCH.
REQ-018 MEMWRITE: mem_write=1, adr_src=1, result_src=00; mem_write held until mem_ready_i=1, then FETCH.
REQ-019 EXECR: srcA=10, srcB=00, alu_op=10; EXECI: srcA=10, srcB=01, alu_op=10; both to ALUWB.
REQ-020 ALUWB: result_src=00, reg_write=1; to FETCH.
REQ-021 JAL: srcA=01, srcB=10, alu_op=00, result_src=00, pc_write=1; to ALUWB.
REQ-022 BRANCH: srcA=10, srcB=00, alu_op=01, result_src=00; pc_write=zero_i XOR funct3_i[0] (beq/bne), same cycle; to FETCH.
REQ-023 imm_src_o combinational from op_i: I-type/load=000, store=001, branch=010, jal=011, lui/auipc=100, other=000.
REQ-024 TRAP: all write/read enables 0, illegal_o=1, state held until reset.
REQ-025 Instruction latency with zero wait states: R/I/jal 4 cycles, load 5, store 4, branch 3.

Reset
REQ-026 rst_ni low SHALL immediately force state FETCH and illegal_o=0, regardless of clock.
REQ-027 During reset outputs SHALL equal FETCH values with ir_write_o=pc_write_o=0; mid-instruction reset abandons the instruction with no write enable asserted.
REQ-028 First FETCH handshake SHALL occur on the first rising edge after rst_ni deasserts.

Configuration
REQ-029 Macro MULTICYCLE_UTYPE_EN defined: UTYPE state present; srcA=11 (zero) for lui, 01 (old PC) for auipc, srcB=01, alu_op=00; to ALUWB.
REQ-030 Macro undefined: UTYPE absent; opcodes 0110111/0010111 decode to TRAP.

Verification
REQ-031 Reset then op_i=0110011, mem_ready_i=1 -> states 0,1,6,7,0; reg_write_o=1 only in state 7.
REQ-032 Load with mem_ready_i low 3 cycles in MEMREAD -> state 3 held 4 cycles, then 4 with result_src_o=01.
REQ-033 op_i=1100011, funct3_i=001, zero_i=0 -> pc_write_o=1 in BRANCH; zero_i=1 -> pc_write_o=0.
REQ-034 op_i=1111111 -> state 12, illegal_o=1 persists; rst_ni low asynchronously -> state 0, illegal_o=0.
REQ-035 op_i=0110111 with macro -> state 11, alu_src_a_o=11, imm_src_o=100; without macro -> state 12.
REQ-036 rst_ni asserted in MEMWRITE -> mem_write_o drops without clock edge; state_o=0.
